// File: rtl/bemicro_cv_pll_lock_mon.sv
// PLL reset sequencer and lock qualifier on refclk: pulses the PLL reset, waits
// for a stable synchronized lock, then releases the system reset and counts lock losses.
module bemicro_cv_pll_lock_mon #(
  parameter int SYNC_STAGES        = 2,
  parameter int PLL_RST_CYCLES     = 16,
  parameter int LOCK_STABLE_CYCLES = 1024,
  parameter int RELOCK_TIMEOUT     = 65536,
  parameter int CNT_W              = 8
) (
  input  logic             refclk,
  input  logic             rst,
  input  logic             pll_locked,
  input  logic             loss_clr,
  output logic             pll_rst,
  output logic             sys_rst,
  output logic             ready,
  output logic [CNT_W-1:0] loss_count,
  output logic [1:0]       dbg_state
);

  localparam int MAX_A   = (PLL_RST_CYCLES > LOCK_STABLE_CYCLES) ? PLL_RST_CYCLES : LOCK_STABLE_CYCLES;
  localparam int MAX_CYC = (MAX_A > RELOCK_TIMEOUT) ? MAX_A : RELOCK_TIMEOUT;
  localparam int TMR_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

  localparam logic [TMR_W-1:0] PLL_RST_LAST = TMR_W'(PLL_RST_CYCLES - 1);
  localparam logic [TMR_W-1:0] STABLE_LAST  = TMR_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [TMR_W-1:0] TIMEOUT_LAST = TMR_W'(RELOCK_TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_PLL_RESET = 2'd0,
    S_WAIT_LOCK = 2'd1,
    S_STABLE    = 2'd2,
    S_RUN       = 2'd3
  } state_t;

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic [SYNC_STAGES-1:0] r_sync;
  logic [TMR_W-1:0]       r_timer;
  logic [TMR_W-1:0]       w_timer_nxt;
  logic                   r_pll_rst;
  logic                   r_sys_rst;
  logic                   r_ready;
  logic [CNT_W-1:0]       r_loss;
  logic                   w_locked_s;
  logic                   w_pll_rst_nxt;
  logic                   w_sys_rst_nxt;
  logic                   w_loss_inc;
  logic [CNT_W-1:0]       w_loss_nxt;

  assign w_locked_s = r_sync[SYNC_STAGES-1];

  // State register; outputs are registered from the next state so they move on the transition edge.
  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      r_state   <= S_PLL_RESET;
      r_sync    <= '0;
      r_timer   <= '0;
      r_pll_rst <= 1'b1;
      r_sys_rst <= 1'b1;
      r_ready   <= 1'b0;
      r_loss    <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_sync    <= {r_sync[SYNC_STAGES-2:0], pll_locked};
      r_timer   <= w_timer_nxt;
      r_pll_rst <= w_pll_rst_nxt;
      r_sys_rst <= w_sys_rst_nxt;
      r_ready   <= ~w_sys_rst_nxt;
      r_loss    <= w_loss_nxt;
    end
  end

  // Next state; a lock seen in WAIT_LOCK takes priority over the timeout.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_PLL_RESET: if (r_timer == PLL_RST_LAST) w_state_nxt = S_WAIT_LOCK;
      S_WAIT_LOCK: begin
        if (w_locked_s)                   w_state_nxt = S_STABLE;
        else if (r_timer == TIMEOUT_LAST) w_state_nxt = S_PLL_RESET;
      end
      S_STABLE: begin
        if (!w_locked_s)                 w_state_nxt = S_WAIT_LOCK;
        else if (r_timer == STABLE_LAST) w_state_nxt = S_RUN;
      end
      S_RUN:   if (!w_locked_s) w_state_nxt = S_WAIT_LOCK;
      default: w_state_nxt = S_PLL_RESET;
    endcase
  end

  // Output and datapath next values; the timer rests at zero in RUN so it never wraps.
  always_comb begin
    w_timer_nxt   = r_timer + TMR_W'(1);
    if ((w_state_nxt != r_state) || (r_state == S_RUN)) w_timer_nxt = '0;
    w_pll_rst_nxt = (w_state_nxt == S_PLL_RESET);
    w_sys_rst_nxt = (w_state_nxt != S_RUN);
    w_loss_inc    = (r_state == S_RUN) && !w_locked_s;
    w_loss_nxt    = r_loss;
    if (loss_clr)                        w_loss_nxt = '0;
    else if (w_loss_inc && ~&r_loss)     w_loss_nxt = r_loss + CNT_W'(1);
  end

  assign pll_rst    = r_pll_rst;
  assign sys_rst    = r_sys_rst;
  assign ready      = r_ready;
  assign loss_count = r_loss;
  assign dbg_state  = r_state;

endmodule

// File: tb/tb_bemicro_cv_pll_lock_mon.sv
// Directed bench for bemicro_cv_pll_lock_mon with short sim parameters;
// every expectation is a hand-counted cycle position or value.
module tb_bemicro_cv_pll_lock_mon;

  localparam int CNT_W = 2;

  logic             refclk;
  logic             rst;
  logic             pll_locked;
  logic             loss_clr;
  logic             pll_rst;
  logic             sys_rst;
  logic             ready;
  logic [CNT_W-1:0] loss_count;
  logic [1:0]       dbg_state;

  int n_checks = 0;
  int n_pass   = 0;

  bemicro_cv_pll_lock_mon #(
    .SYNC_STAGES(2),
    .PLL_RST_CYCLES(4),
    .LOCK_STABLE_CYCLES(8),
    .RELOCK_TIMEOUT(32),
    .CNT_W(CNT_W)
  ) dut (
    .refclk(refclk),
    .rst(rst),
    .pll_locked(pll_locked),
    .loss_clr(loss_clr),
    .pll_rst(pll_rst),
    .sys_rst(sys_rst),
    .ready(ready),
    .loss_count(loss_count),
    .dbg_state(dbg_state)
  );

  // clock / reset
  initial begin
    refclk = 1'b0;
    forever #5 refclk = ~refclk;
  end

  // driver helpers: sample and drive 1 time unit after the rising edge
  task automatic tick();
    @(posedge refclk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    assert (got === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
  endtask

  // states: 0 PLL_RESET, 1 WAIT_LOCK, 2 STABLE, 3 RUN
  initial begin
    rst        = 1'b1;
    pll_locked = 1'b0;
    loss_clr   = 1'b0;
    repeat (3) tick();
    chk("rst_pll_rst", 8'(pll_rst), 8'd1);
    chk("rst_sys_rst", 8'(sys_rst), 8'd1);
    chk("rst_ready",   8'(ready), 8'd0);
    chk("rst_loss",    8'(loss_count), 8'd0);
    chk("rst_state",   8'(dbg_state), 8'd0);

    // Lock held high: PLL reset for 4 edges, 1 edge in WAIT_LOCK, 8 in STABLE.
    pll_locked = 1'b1;
    rst        = 1'b0;
    for (int i = 1; i <= 13; i++) begin
      tick();
      chk("t1_pll_rst", 8'(pll_rst), 8'(i < 4));
      chk("t1_sys_rst", 8'(sys_rst), 8'(i < 13));
    end
    chk("t1_ready", 8'(ready), 8'd1);
    chk("t1_state", 8'(dbg_state), 8'd3);

    // Five losses in RUN: 2 sync edges then the transition edge; count saturates at 3.
    for (int n = 0; n < 5; n++) begin
      pll_locked = 1'b0;
      tick();
      tick();
      chk("t4_hold_sys_rst", 8'(sys_rst), 8'd0);
      tick();
      chk("t4_sys_rst", 8'(sys_rst), 8'd1);
      chk("t4_ready",   8'(ready), 8'd0);
      chk("t4_loss",    8'(loss_count), 8'((n < 2) ? n + 1 : 3));
      pll_locked = 1'b1;
      repeat (11) tick();
      chk("t4_relock_ready", 8'(ready), 8'd1);
    end

    // Clear coincident with a loss: clear wins.
    pll_locked = 1'b0;
    tick();
    tick();
    loss_clr = 1'b1;
    tick();
    loss_clr = 1'b0;
    chk("t5_loss",    8'(loss_count), 8'd0);
    chk("t5_sys_rst", 8'(sys_rst), 8'd1);
    chk("t5_state",   8'(dbg_state), 8'd1);

    // No lock: 32 cycles of WAIT_LOCK then a 4-cycle PLL reset, repeating.
    for (int k = 1; k <= 72; k++) begin
      tick();
      chk("t2_pll_rst", 8'(pll_rst), 8'((k % 36) >= 32));
      chk("t2_sys_rst", 8'(sys_rst), 8'd1);
    end
    chk("t2_state", 8'(dbg_state), 8'd1);

    // One-cycle drop seen while the STABLE timer is 5 restarts qualification.
    pll_locked = 1'b1;
    repeat (3) tick();
    chk("t3_stable", 8'(dbg_state), 8'd2);
    repeat (3) tick();
    pll_locked = 1'b0;
    tick();
    pll_locked = 1'b1;
    tick();
    tick();
    chk("t3_back_wait", 8'(dbg_state), 8'd1);
    chk("t3_loss",      8'(loss_count), 8'd0);
    for (int j = 10; j <= 18; j++) begin
      tick();
      if (j == 10) chk("t3_restable", 8'(dbg_state), 8'd2);
      chk("t3_sys_rst", 8'(sys_rst), 8'(j < 18));
    end
    chk("t3_ready", 8'(ready), 8'd1);

    // Asynchronous reset from RUN with a non-zero loss count.
    pll_locked = 1'b0;
    repeat (3) tick();
    chk("t6_loss_pre", 8'(loss_count), 8'd1);
    pll_locked = 1'b1;
    repeat (11) tick();
    chk("t6_ready_pre", 8'(ready), 8'd1);
    #2 rst = 1'b1;
    #1;
    chk("t6_pll_rst", 8'(pll_rst), 8'd1);
    chk("t6_sys_rst", 8'(sys_rst), 8'd1);
    chk("t6_ready",   8'(ready), 8'd0);
    chk("t6_loss",    8'(loss_count), 8'd0);
    chk("t6_state",   8'(dbg_state), 8'd0);
    tick();
    rst = 1'b0;

    // final report
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
